pma_rx_align: RTL and testbench

- Receive-side PMA code-group aligner for the ten-bit interface.
- Takes the serial bit stream, one bit per clk, either from the line or from the transmit serializer on loopback.
- Finds the 8b/10b comma (K28.5-style 7-bit pattern), locks 10-bit word boundaries to it, and delivers aligned code-groups with a valid strobe and a sync flag.
- It is the receiving end of the transmit PISO path; it replaces the free-running SIPO in the receive chain.

---
 rtl/pma_pkg.sv | 19 +
 rtl/pma_comma_det.sv | 16 +
 rtl/pma_rx_align.sv | 103 ++++++++++
 tb/tb_pma_rx_align.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pma_pkg.sv
// Shared constants and types for the receive-side PMA aligner.
// Optional build macro used by pma_rx_align: PMA_RX_EWRAP_EN.
package pma_pkg;

    localparam logic [6:0] COMMA_P = 7'b0011111;
    localparam logic [6:0] COMMA_N = 7'b1100000;
    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [3:0] WORD_LAST = 4'd9;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } align_state_t;

    function automatic logic is_comma7(input logic [6:0] p);
        return (p == COMMA_P) || (p == COMMA_N);
    endfunction

endpackage

// File: rtl/pma_comma_det.sv
// Combinational comma detector over a 10-bit code-group window.
// Shared with the PCS synchronization block.
module pma_comma_det
    import pma_pkg::*;
(
    input  logic [9:0] win,
    output logic       is_comma
);

    logic unused_tail;

    // The comma is defined by the seven leading bits (a..g) only.
    assign is_comma    = is_comma7(win[9:3]);
    assign unused_tail = ^win[2:0];

endmodule

// File: rtl/pma_rx_align.sv
// Ten-bit interface receive aligner: comma hunt, word lock, loss of sync.
// Build macro PMA_RX_EWRAP_EN adds the ewrap/tx_serial loopback source.
module pma_rx_align
    import pma_pkg::*;
#(
    parameter int LOS_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_in,
`ifdef PMA_RX_EWRAP_EN
    input  logic       ewrap,
    input  logic       tx_serial,
`endif
    output logic [9:0] rx_code_group,
    output logic       rx_valid,
    output logic       comma_det,
    output logic       sync_status,
    output logic [3:0] misalign_cnt
);

    localparam logic [3:0] LOS_MAX = 4'(LOS_LIMIT);

    logic         ser;
    logic [9:0]   sr;
    logic [9:0]   win;
    logic [3:0]   cnt;
    logic         hit;
    logic         unused_msb;
    align_state_t state;

`ifdef PMA_RX_EWRAP_EN
    assign ser = ewrap ? tx_serial : s_in;
`else
    assign ser = s_in;
`endif

    assign win        = {sr[8:0], ser};
    assign unused_msb = sr[9];

    pma_comma_det u_comma_det (
        .win      (win),
        .is_comma (hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr            <= '0;
            cnt           <= '0;
            state         <= HUNT;
            rx_code_group <= '0;
            rx_valid      <= 1'b0;
            comma_det     <= 1'b0;
            sync_status   <= 1'b0;
            misalign_cnt  <= '0;
        end else begin
            sr        <= win;
            rx_valid  <= 1'b0;
            comma_det <= 1'b0;
            case (state)
                HUNT: begin
                    if (hit) begin
                        rx_code_group <= win;
                        rx_valid      <= 1'b1;
                        comma_det     <= 1'b1;
                        cnt           <= '0;
                        misalign_cnt  <= '0;
                        state         <= LOCKED;
                        sync_status   <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (cnt == WORD_LAST) begin
                        rx_code_group <= win;
                        rx_valid      <= 1'b1;
                        comma_det     <= hit;
                        cnt           <= '0;
                        if (hit) begin
                            misalign_cnt <= '0;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                        // A comma off the word boundary counts toward loss of sync.
                        if (hit) begin
                            if (misalign_cnt + 4'd1 == LOS_MAX) begin
                                state        <= HUNT;
                                sync_status  <= 1'b0;
                                misalign_cnt <= '0;
                            end else begin
                                misalign_cnt <= misalign_cnt + 4'd1;
                            end
                        end
                    end
                end
                default: begin
                    state       <= HUNT;
                    sync_status <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pma_rx_align.sv
// Self-checking bench for pma_rx_align against a bit-history reference model.
// Exercises the loopback source as well when PMA_RX_EWRAP_EN is defined.
module tb_pma_rx_align;

    localparam int LOS = 4;
    localparam logic [9:0] KW = 10'b0011111010;
    localparam logic [9:0] DW = 10'b1010101010;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s_in = 1'b0;
    logic [9:0] rx_code_group;
    logic       rx_valid;
    logic       comma_det;
    logic       sync_status;
    logic [3:0] misalign_cnt;
`ifdef PMA_RX_EWRAP_EN
    logic       ewrap = 1'b0;
    logic       tx_serial = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    logic [9:0] m_win = '0;
    logic [9:0] m_word = '0;
    logic       m_locked = 1'b0;
    logic       m_valid = 1'b0;
    logic       m_cdet = 1'b0;
    int         m_pos = 0;
    int         m_mis = 0;

    pma_rx_align #(.LOS_LIMIT(LOS)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_in          (s_in),
`ifdef PMA_RX_EWRAP_EN
        .ewrap         (ewrap),
        .tx_serial     (tx_serial),
`endif
        .rx_code_group (rx_code_group),
        .rx_valid      (rx_valid),
        .comma_det     (comma_det),
        .sync_status   (sync_status),
        .misalign_cnt  (misalign_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [9:0] obs,
                       input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic has_comma(input logic [9:0] w);
        logic [6:0] top;
        top = w[9:3];
        return (top == 7'b0011111) || (top == 7'b1100000);
    endfunction

    // Reference: lock anchors the word grid; a boundary is every 10th bit.
    task automatic model_bit(input logic b);
        logic c;
        m_win   = {m_win[8:0], b};
        c       = has_comma(m_win);
        m_valid = 1'b0;
        m_cdet  = 1'b0;
        if (!m_locked) begin
            if (c) begin
                m_word = m_win; m_valid = 1'b1; m_cdet = 1'b1;
                m_locked = 1'b1; m_pos = 0; m_mis = 0;
            end
        end else begin
            m_pos++;
            if (m_pos % 10 == 0) begin
                m_word = m_win; m_valid = 1'b1; m_cdet = c;
                if (c) m_mis = 0;
            end else if (c) begin
                m_mis++;
                if (m_mis == LOS) begin
                    m_locked = 1'b0; m_mis = 0;
                end
            end
        end
    endtask

    task automatic model_reset();
        m_win = '0; m_word = '0; m_locked = 1'b0;
        m_valid = 1'b0; m_cdet = 1'b0; m_pos = 0; m_mis = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_word"}, rx_code_group, 10'h000);
        chk({tag, "_valid"}, {9'd0, rx_valid}, 10'd0);
        chk({tag, "_cdet"}, {9'd0, comma_det}, 10'd0);
        chk({tag, "_sync"}, {9'd0, sync_status}, 10'd0);
        chk({tag, "_mis"}, {6'd0, misalign_cnt}, 10'd0);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic send_bit(input logic b, input logic use_wrap);
`ifdef PMA_RX_EWRAP_EN
        ewrap = use_wrap;
        if (use_wrap) begin
            tx_serial = b; s_in = 1'b0;
        end else begin
            s_in = b; tx_serial = 1'($urandom);
        end
`else
        s_in = b;
        if (use_wrap) s_in = b;
`endif
        @(posedge clk);
        model_bit(b);
        @(negedge clk);
        chk("valid", {9'd0, rx_valid}, {9'd0, m_valid});
        chk("sync", {9'd0, sync_status}, {9'd0, m_locked});
        chk("mis", {6'd0, misalign_cnt}, 10'(m_mis));
        chk("word", rx_code_group, m_word);
        if (m_valid) chk("cdet", {9'd0, comma_det}, {9'd0, m_cdet});
    endtask

    task automatic send_word(input logic [9:0] w, input logic use_wrap);
        for (int i = 9; i >= 0; i--) send_bit(w[i], use_wrap);
    endtask

    task automatic random_phase(input int n);
        int r;
        logic [9:0] rw;
        for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 9);
            if (r < 4) send_word(KW, 1'b0);
            else if (r < 7) send_word(DW, 1'b0);
            else if (r < 9) begin
                rw = 10'($urandom);
                send_word(rw, 1'b0);
            end else begin
                r = $urandom_range(1, 9);
                for (int j = 0; j < r; j++) send_bit(1'($urandom), 1'b0);
            end
        end
    endtask

    task automatic hold_reset(input string tag);
        for (int i = 0; i < 3; i++) begin
            s_in = 1'($urandom);
            @(negedge clk);
            chk_zero(tag);
        end
        reset = 1'b1;
    endtask

    initial begin
        #1;
        chk_zero("por");
        @(negedge clk);
        hold_reset("rst");

        // Acquisition: 101 then K28.5
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        send_word(KW, 1'b0);
        chk("acq_valid", {9'd0, rx_valid}, 10'd1);
        chk("acq_cdet", {9'd0, comma_det}, 10'd1);
        chk("acq_word", rx_code_group, 10'h0FA);
        chk("acq_sync", {9'd0, sync_status}, 10'd1);

        // Steady stream
        for (int i = 0; i < 3; i++) begin
            send_word(DW, 1'b0);
            chk("st_d", rx_code_group, 10'h2AA);
            send_word(KW, 1'b0);
            chk("st_k", rx_code_group, 10'h0FA);
        end
        send_word(DW, 1'b0);

        // Loss of sync after a one-bit slip
        send_bit(1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            send_word(KW, 1'b0);
            if (i < 4) begin
                chk("los_mis", {6'd0, misalign_cnt}, 10'(i));
                chk("los_sync_hi", {9'd0, sync_status}, 10'd1);
                send_word(DW, 1'b0);
            end
        end
        chk("los_sync_lo", {9'd0, sync_status}, 10'd0);
        chk("los_mis_clr", {6'd0, misalign_cnt}, 10'd0);
        send_word(DW, 1'b0);
        send_word(KW, 1'b0);
        chk("relock_sync", {9'd0, sync_status}, 10'd1);
        chk("relock_word", rx_code_group, 10'h0FA);
        send_word(DW, 1'b0);

        // Recovery: three misaligned commas then an aligned one
        send_bit(1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            send_word(KW, 1'b0);
            chk("rec_mis", {6'd0, misalign_cnt}, 10'(i));
            if (i < 3) send_word(DW, 1'b0);
        end
        for (int i = 0; i < 9; i++) send_bit(i[0] ? 1'b0 : 1'b1, 1'b0);
        send_word(KW, 1'b0);
        chk("rec_mis0", {6'd0, misalign_cnt}, 10'd0);
        chk("rec_sync", {9'd0, sync_status}, 10'd1);
        chk("rec_word", rx_code_group, 10'h0FA);

        random_phase(120);

        // Reset mid-word
        send_word(KW, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1'b0);
        #2 reset = 1'b0;
        #1 chk_zero("mid_async");
        model_reset();
        @(negedge clk);
        hold_reset("mid");
        random_phase(120);

`ifdef PMA_RX_EWRAP_EN
        for (int i = 0; i < 6; i++) send_word(KW, 1'b1);
        chk("wrap_sync", {9'd0, sync_status}, 10'd1);
        chk("wrap_word", rx_code_group, 10'h0FA);
        for (int i = 0; i < 3; i++) send_word(10'h000, 1'b0);
        chk("nowrap_word", rx_code_group, 10'h000);
        chk("nowrap_cdet", {9'd0, comma_det}, 10'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
